// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the CPU run controller.
// Combinational definitions only, no latency.
// No backpressure; consumed by the controller and its bench.
package cpu_ctrl_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_STEP = 2'd2;
  localparam logic [1:0] CMD_STOP = 2'd3;

endpackage

// File: rtl/cpu_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Count visible one cycle after the increment request.
// No backpressure; increments beyond all-ones are dropped.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Host sequencer: loads instruction memory, then runs/steps the CPU with a PC breakpoint.
// Memory writes are combinational from the byte handshake; state changes take one cycle.
// Commands other than STOP stall during LOAD; START and STEP accept nothing.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_cmd_valid,
  input  logic [1:0]         host_cmd,
  output logic               host_cmd_ready,
  input  logic [ADDR_W:0]    load_count,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_run,
  input  logic [ADDR_W-1:0]  cpu_pc,
  input  logic               bp_enable,
  input  logic [ADDR_W-1:0]  bp_addr,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                step_pending_q, step_pending_d;
  logic                first_q, first_d;

  logic                cmd_stop;
  logic                cmd_acc;
  logic                load_fire;
  logic                bp_hit;
  logic [ADDR_W:0]     load_clamped;

  assign cmd_stop     = host_cmd_valid && (host_cmd == CMD_STOP);
  assign cmd_acc      = host_cmd_valid && host_cmd_ready;
  assign load_clamped = (load_count > DEPTH) ? DEPTH : load_count;
  // The first RUN cycle after entry ignores the breakpoint so a halted PC can resume.
  assign bp_hit       = bp_enable && (cpu_pc == bp_addr) && !first_q;

  // Command acceptance: LOAD only lets STOP through so a pending RUN cannot race the load.
  always_comb begin
    host_cmd_ready = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_HALT: host_cmd_ready = 1'b1;
      ST_LOAD:                  host_cmd_ready = (host_cmd == CMD_STOP);
      default:                  host_cmd_ready = 1'b0;
    endcase
  end

  // Byte stream: a STOP presented in the same cycle suppresses the write.
  assign load_ready = (state_q == ST_LOAD) && !cmd_stop;
  assign load_fire  = load_valid && load_ready;
  assign imem_we    = load_fire;
  assign imem_waddr = ptr_q;
  assign imem_wdata = load_data;

  // CPU controls; STOP and breakpoint both block the advance in the cycle they occur.
  always_comb begin
    cpu_run = 1'b0;
    unique case (state_q)
      ST_RUN:  cpu_run = !(cmd_acc && (host_cmd == CMD_STOP)) && !bp_hit;
      ST_STEP: cpu_run = 1'b1;
      default: cpu_run = 1'b0;
    endcase
  end

  assign cpu_reset = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_START);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_START) || (state_q == ST_RUN);
  assign halted    = (state_q == ST_HALT);

  // Next-state logic for the sequencer.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    ptr_d          = ptr_q;
    step_pending_d = step_pending_q;
    first_d        = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          unique case (host_cmd)
            CMD_LOAD: begin
              if (load_clamped != '0) begin
                count_d = load_clamped;
                ptr_d   = '0;
                state_d = ST_LOAD;
              end
            end
            CMD_RUN: begin
              step_pending_d = 1'b0;
              state_d        = ST_START;
            end
            CMD_STEP: begin
              step_pending_d = 1'b1;
              state_d        = ST_START;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (cmd_acc) begin
          state_d = ST_IDLE;
        end else if (load_fire) begin
          ptr_d = ptr_q + 1'b1;
          if ({1'b0, ptr_q} == (count_q - 1'b1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_START: begin
        first_d = 1'b1;
        state_d = step_pending_q ? ST_STEP : ST_RUN;
      end
      ST_RUN: begin
        first_d = 1'b0;
        if (cmd_acc && (host_cmd == CMD_STOP)) begin
          state_d = ST_IDLE;
        end else if (bp_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_HALT: begin
        if (cmd_acc) begin
          unique case (host_cmd)
            CMD_RUN: begin
              first_d = 1'b1;
              state_d = ST_RUN;
            end
            CMD_STEP: state_d = ST_STEP;
            CMD_STOP: state_d = ST_IDLE;
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      ptr_q          <= '0;
      step_pending_q <= 1'b0;
      first_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      ptr_q          <= ptr_d;
      step_pending_q <= step_pending_d;
      first_q        <= first_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q == ST_START),
    .inc_i   (cpu_run),
    .count_o (cycle_count)
  );

endmodule
